// File: rtl/dot_max_engine.sv
// Loads input/weight vectors over valid/ready, then computes an unsigned dot product one MAC per cycle
// and tracks the running maximum and its argmax. Result is final LANES+1 cycles after start; loads stall while busy.
`timescale 1ns/1ps
module dot_max_engine #(
  parameter int  LANES = 4,
  parameter int  DW    = 4,
  parameter int  IDXW  = 8,
  localparam int ACCW  = 2*DW + $clog2(LANES)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sel,
  input  logic [DW-1:0]   in_data,
  input  logic            start,
  input  logic            clear_max,
  output logic            busy,
  output logic            done,
  output logic [ACCW-1:0] dot_out,
  output logic [ACCW-1:0] max_out,
  output logic [IDXW-1:0] max_idx,
  output logic            max_valid
);

  localparam int KW = $clog2(LANES);
  localparam logic [KW-1:0] K_LAST = KW'(LANES-1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    CMP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LANES-1:0][DW-1:0] in_vec;
  logic [LANES-1:0][DW-1:0] w_vec;
  logic [ACCW-1:0]          acc;
  logic [ACCW-1:0]          prod;
  logic [KW-1:0]            k;
  logic [IDXW-1:0]          vec_cnt;
  logic                     load_acc;

  assign in_ready = (state == IDLE);
  assign load_acc = in_valid && in_ready;
  assign prod     = ACCW'(in_vec[k]) * ACCW'(w_vec[k]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = MAC;
      MAC:     if (k == K_LAST) state_nxt = CMP;
      CMP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Element 0 is the oldest word: each accepted word enters at the top and pushes the rest down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_vec <= '0;
      w_vec  <= '0;
    end else if (load_acc) begin
      if (in_sel) begin
        w_vec <= {in_data, w_vec[LANES-1:1]};
      end else begin
        in_vec <= {in_data, in_vec[LANES-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      k         <= '0;
      vec_cnt   <= '0;
      dot_out   <= '0;
      max_out   <= '0;
      max_idx   <= '0;
      max_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done <= 1'b0;
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            k   <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod;
          k   <= k + KW'(1);
        end
        CMP: begin
          dot_out <= acc;
          done    <= 1'b1;
          vec_cnt <= vec_cnt + IDXW'(1);
          // Strict compare keeps the earliest vector on ties.
          if (!max_valid || (acc > max_out)) begin
            max_out   <= acc;
            max_idx   <= vec_cnt;
            max_valid <= 1'b1;
          end
        end
        default: ;
      endcase
      // Placed last so it overrides a coinciding CMP update.
      if (clear_max) begin
        max_out   <= '0;
        max_idx   <= '0;
        max_valid <= 1'b0;
        vec_cnt   <= '0;
      end
    end
  end

endmodule
